// File: rtl/scroll_sequencer_pkg.sv
// Shared types and constants for the VT52 character-buffer scroll sequencer.
package vt52_pkg;
  localparam int ROWS_DEF      = 24;
  localparam int COLS_DEF      = 80;
  localparam int ADDR_BITS_DEF = 11;

  localparam logic [7:0] SPACE_CHAR  = 8'h20;
  localparam logic       SCROLL_UP   = 1'b0;
  localparam logic       SCROLL_DOWN = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    COPY,
    DRAIN,
    CLEAR
  } scroll_state_e;
endpackage

// File: rtl/scroll_sequencer_if.sv
// Command-handler and character-buffer signals of the scroll sequencer.
interface scroll_sequencer_if
  import vt52_pkg::*;
#(
  parameter int ADDR_BITS = ADDR_BITS_DEF
);
  logic                 scroll_req;
  logic                 scroll_dir;
  logic                 scroll_busy;
  logic                 scroll_done;
  logic [7:0]           cmd_wr_char;
  logic [ADDR_BITS-1:0] cmd_wr_addr;
  logic                 cmd_wr_en;
  logic [ADDR_BITS-1:0] buf_rd_addr;
  logic [7:0]           buf_rd_data;
  logic [ADDR_BITS-1:0] buf_wr_addr;
  logic [7:0]           buf_wr_char;
  logic                 buf_wr_en;
  logic                 write_drop;

  modport slave (
    input  scroll_req, scroll_dir, cmd_wr_char, cmd_wr_addr, cmd_wr_en, buf_rd_data,
    output scroll_busy, scroll_done, buf_rd_addr, buf_wr_addr, buf_wr_char, buf_wr_en,
           write_drop
  );

  modport master (
    output scroll_req, scroll_dir, cmd_wr_char, cmd_wr_addr, cmd_wr_en, buf_rd_data,
    input  scroll_busy, scroll_done, buf_rd_addr, buf_wr_addr, buf_wr_char, buf_wr_en,
           write_drop
  );
endinterface

// File: rtl/scroll_sequencer_addr_gen.sv
// Loadable source/destination address counter pair with a down-counting
// cycle counter; last is high on the final cycle of a loaded run.
module scroll_addr_gen
  import vt52_pkg::*;
#(
  parameter int ADDR_BITS = ADDR_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 load,
  input  logic                 step,
  input  logic                 down,
  input  logic [ADDR_BITS-1:0] src_init,
  input  logic [ADDR_BITS-1:0] dst_init,
  input  logic [ADDR_BITS-1:0] cnt_init,
  output logic [ADDR_BITS-1:0] src,
  output logic [ADDR_BITS-1:0] dst,
  output logic                 last
);
  typedef logic [ADDR_BITS-1:0] addr_t;
  localparam addr_t ONE = addr_t'(1);

  addr_t src_q, src_d;
  addr_t dst_q, dst_d;
  addr_t cnt_q, cnt_d;

  always_comb begin
    src_d = src_q;
    dst_d = dst_q;
    cnt_d = cnt_q;
    if (load) begin
      src_d = src_init;
      dst_d = dst_init;
      cnt_d = cnt_init;
    end else if (step) begin
      src_d = down ? src_q - ONE : src_q + ONE;
      dst_d = down ? dst_q - ONE : dst_q + ONE;
      cnt_d = cnt_q - ONE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      src_q <= '0;
      dst_q <= '0;
      cnt_q <= '0;
    end else begin
      src_q <= src_d;
      dst_q <= dst_d;
      cnt_q <= cnt_d;
    end
  end

  assign src  = src_q;
  assign dst  = dst_q;
  assign last = (cnt_q == ONE);
endmodule

// File: rtl/scroll_sequencer.sv
// Owns the character-buffer write port: forwards command writes when idle and
// runs the one-row copy-then-blank scroll engine when requested.
module scroll_sequencer
  import vt52_pkg::*;
#(
  parameter int ROWS      = ROWS_DEF,
  parameter int COLS      = COLS_DEF,
  parameter int ADDR_BITS = ADDR_BITS_DEF
) (
  input  logic               clk,
  input  logic               reset_n,
  scroll_sequencer_if.slave  bus
);
  localparam int CELLS = ROWS * COLS;
  localparam int N     = (ROWS - 1) * COLS;

  typedef logic [ADDR_BITS-1:0] addr_t;

  scroll_state_e state_q, state_d;
  logic          busy_q, busy_d;
  logic          dir_q, dir_d;
  logic          done_q, done_d;
  logic          drop_q, drop_d;
  logic          pend_q, pend_d;
  addr_t         pend_dst_q, pend_dst_d;
  logic          wr_en_q, wr_en_d;
  addr_t         wr_addr_q, wr_addr_d;
  logic [7:0]    wr_char_q, wr_char_d;

  logic  ag_load, ag_step, ag_down, ag_last;
  addr_t ag_src_init, ag_dst_init, ag_cnt_init, ag_src, ag_dst;

  scroll_addr_gen #(.ADDR_BITS(ADDR_BITS)) u_addr_gen (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (ag_load),
    .step     (ag_step),
    .down     (ag_down),
    .src_init (ag_src_init),
    .dst_init (ag_dst_init),
    .cnt_init (ag_cnt_init),
    .src      (ag_src),
    .dst      (ag_dst),
    .last     (ag_last)
  );

  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    dir_d       = dir_q;
    done_d      = 1'b0;
    drop_d      = drop_q | (bus.cmd_wr_en & busy_q);
    pend_d      = 1'b0;
    pend_dst_d  = ag_dst;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_char_d   = wr_char_q;
    ag_load     = 1'b0;
    ag_step     = 1'b0;
    ag_down     = 1'b0;
    ag_src_init = '0;
    ag_dst_init = '0;
    ag_cnt_init = '0;

    // Read data for the previous cycle's source address is written here.
    if (pend_q) begin
      wr_en_d   = 1'b1;
      wr_addr_d = pend_dst_q;
      wr_char_d = bus.buf_rd_data;
    end

    case (state_q)
      IDLE: begin
        if (bus.cmd_wr_en) begin
          wr_en_d   = 1'b1;
          wr_addr_d = bus.cmd_wr_addr;
          wr_char_d = bus.cmd_wr_char;
        end
        if (bus.scroll_req) begin
          state_d     = COPY;
          busy_d      = 1'b1;
          dir_d       = bus.scroll_dir;
          ag_load     = 1'b1;
          ag_cnt_init = addr_t'(N);
          ag_src_init = (bus.scroll_dir == SCROLL_DOWN) ? addr_t'(N - 1) : addr_t'(COLS);
          ag_dst_init = (bus.scroll_dir == SCROLL_DOWN) ? addr_t'(CELLS - 1) : '0;
        end
      end
      COPY: begin
        pend_d  = 1'b1;
        ag_down = (dir_q == SCROLL_DOWN);
        // Holding on the last read keeps the counters inside the screen.
        ag_step = ~ag_last;
        if (ag_last) state_d = DRAIN;
      end
      DRAIN: begin
        ag_load     = 1'b1;
        ag_dst_init = (dir_q == SCROLL_DOWN) ? '0 : addr_t'(N);
        ag_cnt_init = addr_t'(COLS);
        state_d     = CLEAR;
      end
      CLEAR: begin
        wr_en_d   = 1'b1;
        wr_addr_d = ag_dst;
        wr_char_d = SPACE_CHAR;
        ag_step   = ~ag_last;
        if (ag_last) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      dir_q      <= 1'b0;
      done_q     <= 1'b0;
      drop_q     <= 1'b0;
      pend_q     <= 1'b0;
      pend_dst_q <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_char_q  <= '0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      dir_q      <= dir_d;
      done_q     <= done_d;
      drop_q     <= drop_d;
      pend_q     <= pend_d;
      pend_dst_q <= pend_dst_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_char_q  <= wr_char_d;
    end
  end

  // scroll_req is folded in so the handler sees busy on its request edge.
  assign bus.scroll_busy = busy_q | bus.scroll_req;
  assign bus.scroll_done = done_q;
  assign bus.buf_rd_addr = ag_src;
  assign bus.buf_wr_en   = wr_en_q;
  assign bus.buf_wr_addr = wr_addr_q;
  assign bus.buf_wr_char = wr_char_q;
  assign bus.write_drop  = drop_q;
endmodule
